// File: rtl/frame_pkg.sv
// Shared geometry for the 8x8 double-buffered frame store and its bench.
package frame_pkg;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int FRAME_W = ROWS * COLS;
  localparam int CNT_W   = 16;

  function automatic logic [COLS-1:0] row_slice(input logic [FRAME_W-1:0] f, input int r);
    return f[r*COLS +: COLS];
  endfunction
endpackage

// File: rtl/frame_buffer_if.sv
// Write/commit bus plus frame-boundary and front-buffer outputs of frame_buffer.
interface frame_buffer_if
  import frame_pkg::*;
#(
  parameter int NR = frame_pkg::ROWS,
  parameter int NC = frame_pkg::COLS,
  parameter int CW = frame_pkg::CNT_W
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [$clog2(NR)-1:0]  wr_row;
  logic [NC-1:0]          wr_data;
  logic                   clear;
  logic                   commit;
  logic                   latch;
  logic                   commit_pending;
  logic [NR*NC-1:0]       frame_out;
  logic [CW-1:0]          frame_count;

  modport master (
    output wr_valid, wr_row, wr_data, clear, commit, latch,
    input  wr_ready, commit_pending, frame_out, frame_count
  );
  modport slave (
    input  wr_valid, wr_row, wr_data, clear, commit, latch,
    output wr_ready, commit_pending, frame_out, frame_count
  );
endinterface

// File: rtl/frame_buffer_rise_detect.sv
// Rising-edge detector; the delayed copy resets low so a level held high
// across reset release is reported as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store: edits go to the back buffer, and a commit copies
// it to the front buffer only on the first cycle of the shifter's latch phase.
module frame_buffer #(
  parameter int ROWS  = frame_pkg::ROWS,
  parameter int COLS  = frame_pkg::COLS,
  parameter int CNT_W = frame_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  frame_buffer_if.slave  bus
);
  import frame_pkg::*;

  localparam int RW = $clog2(ROWS);

  logic [ROWS*COLS-1:0] back;
  logic [ROWS*COLS-1:0] front;
  logic                 pending;
  logic [CNT_W-1:0]     cnt;
  logic                 rise;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.latch),
    .rise (rise)
  );

  // Back buffer is frozen while a commit waits, so the copied frame is exactly
  // what was visible when commit was accepted.
  assign bus.wr_ready       = ~pending;
  assign bus.commit_pending = pending;
  assign bus.frame_out      = front;
  assign bus.frame_count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      back    <= '0;
      front   <= '0;
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      if (!pending) begin
        if (bus.clear) back <= '0;
        else if (bus.wr_valid)
          // Rows past ROWS match no slot, so such writes drop silently.
          for (int r = 0; r < ROWS; r++)
            if (bus.wr_row == RW'(r)) back[r*COLS +: COLS] <= bus.wr_data;
      end
      if (rise && pending) begin
        front   <= back;
        pending <= 1'b0;
        cnt     <= cnt + 1'b1;
      end else if (bus.commit && !pending) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer.sv
// Randomised + directed check of frame_buffer against a row-array reference model.
module tb_frame_buffer;
  import frame_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  frame_buffer_if bus ();

  frame_buffer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: rows as bytes, a pending flag, a copy counter
  logic [7:0]  m_back  [8];
  logic [7:0]  m_front [8];
  logic        m_pend;
  logic [15:0] m_cnt;
  logic        m_latch_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_frame();
    logic [63:0] f;
    for (int r = 0; r < 8; r++) f[r*8 +: 8] = m_front[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_back[r]  = 8'h00;
      m_front[r] = 8'h00;
    end
    m_pend       = 1'b0;
    m_cnt        = 16'h0000;
    m_latch_prev = 1'b0;
  endtask

  task automatic compare();
    chk("wr_ready", 64'(bus.wr_ready), 64'(!m_pend));
    chk("commit_pending", 64'(bus.commit_pending), 64'(m_pend));
    chk("frame_out", bus.frame_out, m_frame());
    chk("frame_count", 64'(bus.frame_count), 64'(m_cnt));
    for (int r = 0; r < 8; r++)
      if (row_slice(bus.frame_out, r) !== m_front[r])
        $display("  row %0d differs: %h vs %h", r, row_slice(bus.frame_out, r), m_front[r]);
  endtask

  // one clock: advance the model from the applied inputs, then check
  task automatic step();
    logic [7:0]  nb [8];
    logic [7:0]  nf [8];
    logic        np;
    logic [15:0] nc;
    logic        boundary;
    boundary = bus.latch && !m_latch_prev;
    for (int r = 0; r < 8; r++) begin
      nb[r] = m_back[r];
      nf[r] = m_front[r];
    end
    np = m_pend;
    nc = m_cnt;
    if (!m_pend) begin
      if (bus.clear) for (int r = 0; r < 8; r++) nb[r] = 8'h00;
      else if (bus.wr_valid) nb[int'(bus.wr_row)] = bus.wr_data;
    end
    if (boundary && m_pend) begin
      for (int r = 0; r < 8; r++) nf[r] = m_back[r];
      np = 1'b0;
      nc = m_cnt + 16'd1;
    end else if (bus.commit && !m_pend) begin
      np = 1'b1;
    end
    @(posedge clk);
    for (int r = 0; r < 8; r++) begin
      m_back[r]  = nb[r];
      m_front[r] = nf[r];
    end
    m_pend       = np;
    m_cnt        = nc;
    m_latch_prev = bus.latch;
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.wr_row   = '0;
    bus.wr_data  = '0;
    bus.clear    = 1'b0;
    bus.commit   = 1'b0;
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'(r);
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic latch_pulse();
    bus.latch = 1'b1;
    repeat (3) step();
    bus.latch = 1'b0;
    step();
  endtask

  initial begin
    int ph;
    int period;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.latch = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    chk("rst_frame", bus.frame_out, 64'h0);
    chk("rst_ready", 64'(bus.wr_ready), 64'h1);
    chk("rst_pending", 64'(bus.commit_pending), 64'h0);
    chk("rst_count", 64'(bus.frame_count), 64'h0);
    rst = 1'b0;
    step();

    // full frame of ones, then reset in the middle of the following frame
    for (int r = 0; r < 8; r++) write_row(r, 8'hFF);
    do_commit();
    latch_pulse();
    chk("ones_frame", bus.frame_out, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.latch = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_frame", bus.frame_out, 64'h0);
    chk("async_rst_ready", 64'(bus.wr_ready), 64'h1);
    chk("async_rst_count", 64'(bus.frame_count), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.latch = 1'b0;
    step();

    // single row, long latch pulse copies once
    write_row(3, 8'hA5);
    do_commit();
    latch_pulse();
    chk("a5_frame", bus.frame_out, 64'h0000_0000_A500_0000);
    chk("a5_count", 64'(bus.frame_count), 64'd1);

    // writes blocked while pending
    do_commit();
    write_row(0, 8'hFF);
    chk("busy_ready", 64'(bus.wr_ready), 64'h0);
    latch_pulse();
    chk("busy_frame", bus.frame_out, 64'h0000_0000_A500_0000);
    chk("busy_count", 64'(bus.frame_count), 64'd2);

    // commit coincident with boundary waits for the next one
    bus.latch  = 1'b1;
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("coinc_pending", 64'(bus.commit_pending), 64'h1);
    chk("coinc_count", 64'(bus.frame_count), 64'd2);
    step();
    step();
    bus.latch = 1'b0;
    step();
    latch_pulse();
    chk("coinc_count2", 64'(bus.frame_count), 64'd3);

    // clear beats same-cycle write
    bus.clear    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd2;
    bus.wr_data  = 8'h5A;
    step();
    idle();
    do_commit();
    latch_pulse();
    chk("clear_frame", bus.frame_out, 64'h0);

    // diagonal for the shifter: line r high only on its r-th bit
    for (int r = 0; r < 8; r++) write_row(r, 8'(1 << r));
    do_commit();
    latch_pulse();
    chk("diag_frame", bus.frame_out, 64'h8040_2010_0804_0201);
    chk("diag_count", 64'(bus.frame_count), 64'd5);

    // random traffic with a free-running latch cadence
    ph = 0;
    period = 10;
    for (int i = 0; i < 3000; i++) begin
      bus.wr_valid = 1'($urandom % 2);
      bus.wr_row   = 3'($urandom);
      bus.wr_data  = 8'($urandom);
      bus.clear    = ($urandom % 16) == 0;
      bus.commit   = ($urandom % 6) == 0;
      bus.latch    = ph < 3;
      ph++;
      if (ph >= period) begin
        ph = 0;
        period = 5 + int'($urandom % 10);
      end
      step();
    end
    idle();
    bus.latch = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
